// File: rtl/reg_file_sb.sv
// Parametrised integer register file with x0 hardwired to zero, optional writeback-to-read
// bypass and a per-register busy scoreboard for the pipeline hazard unit.
module reg_file_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned AW     = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            flush,
  output logic            any_busy
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic wb_live;
  logic iss_live;

  assign wb_live  = wb_en && (wb_addr != '0);
  assign iss_live = iss_en && (iss_addr != '0);

  // Later assignments take priority: flush over issue over writeback.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_live) begin
      regs_d[wb_addr] = wb_data;
      busy_d[wb_addr] = 1'b0;
    end
    if (flush) begin
      busy_d = '0;
    end else if (iss_live) begin
      busy_d[iss_addr] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs1_busy = busy_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
    rs2_busy = busy_q[rs2_addr];

    if (BYPASS && wb_live && (wb_addr == rs1_addr)) begin
      rs1_data = wb_data;
      rs1_busy = iss_en && (iss_addr == rs1_addr);
    end
    if (BYPASS && wb_live && (wb_addr == rs2_addr)) begin
      rs2_data = wb_data;
      rs2_busy = iss_en && (iss_addr == rs2_addr);
    end

    if (rs1_addr == '0) begin
      rs1_data = '0;
      rs1_busy = 1'b0;
    end
    if (rs2_addr == '0) begin
      rs2_data = '0;
      rs2_busy = 1'b0;
    end

    // Bypass paths would otherwise leak strobes through while reset is held.
    if (reset) begin
      rs1_data = '0;
      rs1_busy = 1'b0;
      rs2_data = '0;
      rs2_busy = 1'b0;
    end
  end

  assign any_busy = (|busy_q) && !reset;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus random traffic against an array model,
// run on a bypassing and a non-bypassing instance driven in parallel.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr, wb_addr, iss_addr;
  logic [31:0] wb_data;
  logic        wb_en, iss_en, flush;

  logic [31:0] b1_rs1_data, b1_rs2_data, b0_rs1_data, b0_rs2_data;
  logic        b1_rs1_busy, b1_rs2_busy, b1_any_busy;
  logic        b0_rs1_busy, b0_rs2_busy, b0_any_busy;

  logic [31:0] m_mem  [32];
  logic        m_busy [32];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b1_rs1_data), .rs2_data(b1_rs2_data),
    .rs1_busy(b1_rs1_busy), .rs2_busy(b1_rs2_busy),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .any_busy(b1_any_busy)
  );

  reg_file_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b0_rs1_data), .rs2_data(b0_rs2_data),
    .rs1_busy(b0_rs1_busy), .rs2_busy(b0_rs2_busy),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .any_busy(b0_any_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] e_data(input logic [4:0] a, input bit byp);
    if (reset || a == 5'd0) return 32'h0;
    if (byp && wb_en && wb_addr == a) return wb_data;
    return m_mem[a];
  endfunction

  function automatic logic e_busy(input logic [4:0] a, input bit byp);
    if (reset || a == 5'd0) return 1'b0;
    if (byp && wb_en && wb_addr == a) return iss_en && iss_addr == a;
    return m_busy[a];
  endfunction

  function automatic logic e_any();
    logic r = 1'b0;
    if (reset) return 1'b0;
    for (int i = 1; i < 32; i++) r = r | m_busy[i];
    return r;
  endfunction

  task automatic check_all();
    chk("byp.rs1_data", b1_rs1_data, e_data(rs1_addr, 1'b1));
    chk("byp.rs2_data", b1_rs2_data, e_data(rs2_addr, 1'b1));
    chk("byp.rs1_busy", 32'(b1_rs1_busy), 32'(e_busy(rs1_addr, 1'b1)));
    chk("byp.rs2_busy", 32'(b1_rs2_busy), 32'(e_busy(rs2_addr, 1'b1)));
    chk("byp.any_busy", 32'(b1_any_busy), 32'(e_any()));
    chk("nob.rs1_data", b0_rs1_data, e_data(rs1_addr, 1'b0));
    chk("nob.rs2_data", b0_rs2_data, e_data(rs2_addr, 1'b0));
    chk("nob.rs1_busy", 32'(b0_rs1_busy), 32'(e_busy(rs1_addr, 1'b0)));
    chk("nob.rs2_busy", 32'(b0_rs2_busy), 32'(e_busy(rs2_addr, 1'b0)));
    chk("nob.any_busy", 32'(b0_any_busy), 32'(e_any()));
  endtask

  // Check combinational outputs mid-cycle, then advance the model across the edge.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wb_en && wb_addr != 5'd0) begin
        m_mem[wb_addr]  = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (iss_en && iss_addr != 5'd0) begin
        m_busy[iss_addr] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    wb_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    reset = 1'b1; idle();
    rs1_addr = 5'd0; rs2_addr = 5'd0; wb_addr = 5'd0; iss_addr = 5'd0; wb_data = 32'h0;
    tick();
    chk("reset.any_busy", 32'(b1_any_busy), 32'h0);
    reset = 1'b0;
    tick();

    // Mid-cycle reset after a write to r5
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; iss_en = 1'b1; iss_addr = 5'd8;
    tick();
    idle(); rs1_addr = 5'd5; rs2_addr = 5'd8;
    #2;
    chk("pre_rst.r5", b1_rs1_data, 32'hDEADBEEF);
    chk("pre_rst.any", 32'(b1_any_busy), 32'h1);
    reset = 1'b1; wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h1234; iss_en = 1'b1; iss_addr = 5'd9;
    #1;
    chk("rst.r5_data", b1_rs1_data, 32'h0);
    chk("rst.any_busy", 32'(b1_any_busy), 32'h0);
    chk("rst.byp_data", b1_rs1_data | b1_rs2_data, 32'h0);
    tick();
    reset = 1'b0; idle();
    tick();
    for (int a = 1; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(a);
      #1;
      chk("post_rst.zero", b1_rs1_data | b0_rs2_data, 32'h0);
      tick();
    end

    // x0 hardwire
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF; rs1_addr = 5'd0;
    tick();
    idle();
    #1;
    chk("x0.data", b1_rs1_data, 32'h0);
    chk("x0.busy", 32'(b1_rs1_busy), 32'h0);
    tick();

    // Bypass
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h11;
    tick();
    wb_data = 32'h22; rs2_addr = 5'd7;
    #1;
    chk("byp.same_cycle", b1_rs2_data, 32'h22);
    chk("nob.same_cycle", b0_rs2_data, 32'h11);
    tick();
    idle();
    #1;
    chk("byp.next_cycle", b1_rs2_data, 32'h22);
    chk("nob.next_cycle", b0_rs2_data, 32'h22);
    tick();

    // Scoreboard lifecycle on r3
    iss_en = 1'b1; iss_addr = 5'd3; rs1_addr = 5'd3;
    tick();
    idle();
    #1;
    chk("sb.busy_set", 32'(b1_rs1_busy), 32'h1);
    chk("sb.any_set", 32'(b1_any_busy), 32'h1);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h5;
    tick();
    idle();
    #1;
    chk("sb.busy_clr", 32'(b1_rs1_busy), 32'h0);
    chk("sb.any_clr", 32'(b0_any_busy), 32'h0);
    chk("sb.data", b0_rs1_data, 32'h5);
    tick();

    // Issue/writeback collision on r9
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hA; rs1_addr = 5'd9;
    #1;
    chk("coll.byp_busy", 32'(b1_rs1_busy), 32'h1);
    chk("coll.byp_data", b1_rs1_data, 32'hA);
    tick();
    idle();
    #1;
    chk("coll.after_data", b0_rs1_data, 32'hA);
    chk("coll.after_busy", 32'(b0_rs1_busy), 32'h1);
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hB;
    tick();
    idle();

    // Flush with a concurrent issue and writeback
    for (int k = 0; k < 3; k++) begin
      iss_en = 1'b1; iss_addr = (k == 0) ? 5'd2 : (k == 1) ? 5'd4 : 5'd31;
      tick();
    end
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h77;
    tick();
    idle(); rs1_addr = 5'd6; rs2_addr = 5'd10;
    #1;
    chk("flush.any", 32'(b1_any_busy), 32'h0);
    chk("flush.r6_busy", 32'(b1_rs1_busy), 32'h0);
    chk("flush.wb_data", b1_rs2_data, 32'h77);
    tick();

    // Random traffic, addresses biased to a small window for collisions
    for (int c = 0; c < 400; c++) begin
      logic [4:0] hi;
      hi = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
      rs1_addr = 5'($urandom_range(0, 31) & hi);
      rs2_addr = 5'($urandom_range(0, 31) & hi);
      wb_en    = 1'($urandom_range(0, 1));
      wb_addr  = 5'($urandom_range(0, 31) & hi);
      wb_data  = $urandom;
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = 5'($urandom_range(0, 31) & hi);
      flush    = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised register file with integer-pipeline support, for the pipelined core.
- Generalises width and depth.
- Hardwires register 0 to zero.
- Adds asynchronous reset clearing of all registers.
- Adds optional write-to-read bypass.
- Adds a per-register scoreboard (busy bits): the issue stage marks destinations pending and the writeback stage clears them, so the hazard unit can stall.

Parameters:
XLEN, 32, data width of each register in bits.
NREGS, 32, number of architectural registers (power of two, >=2).
AW, 5, address width; must equal log2(NREGS).
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = reads return stored value only.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
rs1_addr  in  AW  read port 1 address.
rs2_addr  in  AW  read port 2 address.
rs1_data  out  XLEN  read port 1 data (combinational).
rs2_data  out  XLEN  read port 2 data (combinational).
rs1_busy  out  1  register at rs1_addr has an outstanding write.
rs2_busy  out  1  register at rs2_addr has an outstanding write.
wb_en  in  1  writeback strobe.
wb_addr  in  AW  writeback destination.
wb_data  in  XLEN  writeback data.
iss_en  in  1  issue strobe; marks iss_addr pending.
iss_addr  in  AW  issued instruction destination.
flush  in  1  synchronous clear of all busy bits (pipeline flush).
any_busy  out  1  OR of all busy bits (drain detect for fence/CSR).

Behaviour:
Reset:
- reset=1 asynchronously clears every register and every busy bit.
- While reset is high, all outputs are 0, independent of clk and strobes.
- Reset deassertion takes effect at the next rising clk edge.
- A reset asserted mid-operation discards any write or issue in that cycle.

Storage:
- NREGS x XLEN flops. Register 0 is never written: a wb_en to address 0 is ignored.
- Register 0 always reads 0 with busy 0.

Write:
- On the rising edge with wb_en=1 and wb_addr!=0, the register at wb_addr takes wb_data.
- The write is visible from storage on the following cycle.

Read (combinational, zero latency):
- rsN_addr=0 gives rsN_data=0 and rsN_busy=0.
- With BYPASS=1, wb_en=1 and wb_addr=rsN_addr!=0: rsN_data=wb_data and rsN_busy=0 in the same cycle.
  - Exception: if iss_en=1 and iss_addr equals that address in the same cycle, rsN_busy=1.
- Otherwise rsN_data = stored value and rsN_busy = stored busy bit.
- With BYPASS=0: stored values only, and busy reflects state before the edge.

Scoreboard (per register r != 0), next-state at each rising edge, in priority order:
1. flush=1: busy[r] becomes 0 for all r; iss_en is ignored that cycle; the wb data write still occurs.
2. iss_en=1 and iss_addr=r: busy[r] becomes 1. Issue beats a same-cycle writeback to the same register, because the newer producer wins.
3. wb_en=1 and wb_addr=r: busy[r] becomes 0.
4. Otherwise busy[r] holds.

Scoreboard boundary cases:
- Issue to an already-busy register is legal. The bit stays 1; the in-order pipeline guarantees a single writeback clears it.
- Writeback to a non-busy register is legal. Data is written and busy stays 0.
- iss_addr=0 has no effect.
- any_busy is the registered OR of busy bits, i.e. state after the last edge, not bypassed.

Simultaneous events:
- wb and iss to different addresses are independent.
- Both read ports may address the same register.

Test Plan:
- Reset then read: assert reset mid-cycle after writing 0xDEADBEEF to r5 -> rs1_data(r5)=0 immediately and any_busy=0; after deassertion, r1..r31 all read 0.
- x0 hardwire: wb_en=1, wb_addr=0, wb_data=0xFFFFFFFF; next cycle rs1_addr=0 -> rs1_data=0 and rs1_busy=0.
- Bypass: BYPASS=1, r7=0x11, same cycle wb r7=0x22 with rs2_addr=7 -> rs2_data=0x22 that cycle and 0x22 the next.
  - BYPASS=0 instance: 0x11 the same cycle, 0x22 the next.
- Scoreboard lifecycle: iss r3 -> next cycle rs1_busy=1 and any_busy=1; wb r3=0x5 -> next cycle busy=0 and any_busy=0, rs1_data=0x5.
- Issue/writeback collision: r9 busy; same edge iss r9 and wb r9=0xA -> r9=0xA and busy[r9]=1 afterwards.
  - Same cycle with BYPASS=1: rs1_addr=9 -> rs1_busy=1 and rs1_data=0xA.
- Flush: set busy on r2, r4 and r31, then flush=1 together with iss r6 -> all busy 0 and any_busy=0 next cycle, r6 not busy.
  - A wb in the flush cycle still updates data.
